// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S constants and receive-FSM state type.
package i2s_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_BITS_DEF = 32;
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
endpackage

// File: rtl/i2s_rx_in_sync.sv
// i2s_in_sync: 2-FF synchronizer with registered rising-edge detect.
module i2s_in_sync (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);
    logic r_m, r_s, r_p, r_rise;
    // level is taken one flop later so it lines up with the registered rise
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            {r_m, r_s, r_p, r_rise} <= '0;
        end else begin
            r_m    <= pin;
            r_s    <= r_m;
            r_p    <= r_s;
            r_rise <= r_s & ~r_p;
        end
    end
    assign level = r_p;
    assign rise  = r_rise;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver producing paired left/right samples in the clk_50MHz domain.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_BITS = MAX_BITS_DEF
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              adc_SCLK,
    input  logic              adc_LRCK,
    input  logic              adc_SDOUT,
    output logic [DATA_W-1:0] L_data,
    output logic [DATA_W-1:0] R_data,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int            CW   = $clog2(MAX_BITS + 1);
    localparam logic [CW-1:0] DW_C = CW'(DATA_W);
    localparam logic [CW-1:0] MB_C = CW'(MAX_BITS);

    logic w_sclk_rise, w_sclk_lvl, w_lr, w_lr_rise, w_sd, w_sd_rise, w_unused;
    logic w_trans, w_full, w_valid, w_err;
    logic r_hold_v, r_prev_lr, r_primed, r_valid, r_err;
    logic [CW-1:0] r_cnt, w_cnt_inc;
    logic [DATA_W-1:0] r_shift, w_shift_inc, r_hold, r_l, r_r;
    state_t r_state, w_next;

    i2s_in_sync u_sclk (.clk_50MHz(clk_50MHz), .reset(reset), .pin(adc_SCLK), .level(w_sclk_lvl), .rise(w_sclk_rise));
    i2s_in_sync u_lrck (.clk_50MHz(clk_50MHz), .reset(reset), .pin(adc_LRCK), .level(w_lr), .rise(w_lr_rise));
    i2s_in_sync u_sdo  (.clk_50MHz(clk_50MHz), .reset(reset), .pin(adc_SDOUT), .level(w_sd), .rise(w_sd_rise));
    assign w_unused = ^{w_sclk_lvl, w_lr_rise, w_sd_rise};

    // the bit sampled on an LRCK change closes the previous word
    always_comb begin
        w_trans     = w_sclk_rise & r_primed & (w_lr != r_prev_lr);
        w_cnt_inc   = (r_cnt == MB_C) ? r_cnt : r_cnt + 1'b1;
        w_shift_inc = (r_cnt < DW_C) ? {r_shift[DATA_W-2:0], w_sd} : r_shift;
        w_full      = w_cnt_inc >= DW_C;
        w_next      = w_trans ? (w_lr ? RIGHT : LEFT) : r_state;
        w_err       = w_trans & (r_state != SYNC) & ~w_full;
        w_valid     = w_trans & (r_state == RIGHT) & w_full & r_hold_v;
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) r_state <= SYNC;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_hold    <= '0;
            r_hold_v  <= 1'b0;
            r_prev_lr <= 1'b0;
            r_primed  <= 1'b0;
            r_l       <= '0;
            r_r       <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_err   <= w_err;
            if (w_sclk_rise) begin
                r_primed  <= 1'b1;
                r_prev_lr <= w_lr;
                r_cnt     <= w_trans ? '0 : w_cnt_inc;
                r_shift   <= w_trans ? '0 : w_shift_inc;
            end
            if (w_trans && r_state == LEFT && w_full) r_hold <= w_shift_inc;
            if (w_trans && r_state != SYNC) r_hold_v <= (r_state == LEFT) & w_full;
            if (w_valid) begin
                r_l <= r_hold;
                r_r <= w_shift_inc;
            end
        end
    end

    assign L_data       = r_l;
    assign R_data       = r_r;
    assign sample_valid = r_valid;
    assign frame_err    = r_err;
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning output sample width per channel.
REQ-002 SHALL have parameter MAX_BITS, default 32, meaning the largest word length tolerated per channel (bit counter saturates here).
REQ-003 SHALL have port clk_50MHz  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port adc_SCLK  input  1  I2S bit clock from the external ADC; asynchronous to clk_50MHz.
REQ-006 SHALL have port adc_LRCK  input  1  I2S word select (0 = left, 1 = right); asynchronous.
REQ-007 SHALL have port adc_SDOUT  input  1  I2S serial data, MSB first; asynchronous.
REQ-008 SHALL have port L_data  output  DATA_W  last complete left sample.
REQ-009 SHALL have port R_data  output  DATA_W  last complete right sample, paired with L_data.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse when L_data/R_data update.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a word shorter than DATA_W bits ends.

Function
REQ-012 SHALL pass all three inputs through 2-FF synchronizers, then detect an adc_SCLK rising edge as synced=1 and previous synced=0.
REQ-013 SHALL sample synced adc_LRCK and adc_SDOUT together in the clk_50MHz cycle in which the SCLK rising edge is detected; no other cycle samples them.
REQ-014 SHALL support adc_SCLK up to clk_50MHz/4 (12.5 MHz); faster operation is out of scope.
REQ-015 SHALL implement the standard I2S one-bit delay: the bit sampled on the first SCLK edge where LRCK differs from the previous sample SHALL be the last bit (LSB) of the previous channel word.
REQ-016 SHALL shift bits into a DATA_W shift register MSB-first while bit count < DATA_W; bits beyond DATA_W SHALL be discarded (MSB-aligned truncation).
REQ-017 SHALL count bits per word, with the count saturating at MAX_BITS; the count SHALL include the closing bit of REQ-015.
REQ-018 SHALL run FSM states SYNC, LEFT, RIGHT. SYNC is left on the first observed LRCK transition, entering LEFT on 1->0 and RIGHT on 0->1. LEFT->RIGHT occurs on 0->1 and RIGHT->LEFT on 1->0.
REQ-019 SHALL discard the partial word that ends on the transition that leaves SYNC; no output or error is produced for it.
REQ-020 SHALL latch a completed left word (count >= DATA_W) into an internal left holding register on the LEFT->RIGHT transition.
REQ-021 SHALL, on the RIGHT->LEFT transition with a right word of count >= DATA_W and a valid held left word, update L_data and R_data simultaneously and pulse sample_valid.
REQ-022 SHALL assert sample_valid and the new L_data/R_data values in the clk_50MHz cycle after the detect cycle, which is 4 clk_50MHz cycles after the adc_SCLK pin rising edge.
REQ-023 SHALL, for a word ending with count < DATA_W, pulse frame_err with the same timing as REQ-022; the word is not stored. A short left word SHALL invalidate the held left word so the following right word produces no sample_valid.
REQ-024 SHALL hold L_data and R_data stable between sample_valid pulses.
REQ-025 SHALL keep sample_valid and frame_err high for exactly one cycle per event and never assert them in the same cycle.

Reset
REQ-026 SHALL, while reset is high at a clk_50MHz edge, clear L_data, R_data, sample_valid, frame_err, shift register, bit count, held left word and its valid flag, and synchronizer flops to 0, and force the FSM to SYNC.
REQ-027 SHALL, on reset asserted mid-word, discard that word; after reset the block SHALL resynchronise per REQ-018/REQ-019.

Structure
REQ-028 SHALL place the FSM state enum (SYNC, LEFT, RIGHT) and the default DATA_W/MAX_BITS constants in shared package i2s_pkg, also used by audio output blocks.
REQ-029 SHALL implement synchronizer plus edge detect as sub-module i2s_in_sync, instantiated once per input pin, with outputs level and rise.

Verification
REQ-030 SHALL cover standard frame: SCLK 3.072 MHz, 32 bits/channel, L=16'hA55A, R=16'h1234 -> after the second full frame, sample_valid pulses with L_data=A55A and R_data=1234, 4 clk after the SCLK edge closing the right word.
REQ-031 SHALL cover exact-width frame: 16 bits/channel, L=16'h8001, R=16'h7FFE -> L_data=8001, R_data=7FFE, one pulse per frame, no frame_err.
REQ-032 SHALL cover short word: a 12-bit left word followed by a 16-bit right word of 16'hFFFF -> frame_err pulses once, no sample_valid, outputs unchanged, and the next full frame recovers normally.
REQ-033 SHALL cover startup mid-frame: reset released while LRCK=1 with 10 bits already sent -> no sample_valid or frame_err until the first complete L+R pair.
REQ-034 SHALL cover reset mid-word: reset asserted 3 clk_50MHz cycles during a left word -> all outputs 0 next cycle, FSM in SYNC, first valid sample only after a new full pair.
REQ-035 SHALL cover max-speed clock: SCLK = clk_50MHz/4 with a random data stream -> every transmitted pair received bit-exact, with a sample_valid count equal to the frame count minus 1.
